// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Holds the program counter, reads 16-bit instruction
// words from program memory over a request/acknowledge handshake, and presents
// the latched word on fullBitNum to the ALU control FSM. The FSM moves the PC
// with PC_inc / pc_load and asks for the next instruction with done.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_addr     out  program memory address (always equals pc)
//   mem_rd       out  read request, high only while fetching
//   mem_data     in   instruction word, sampled only with mem_ack in FETCH
//   mem_ack      in   memory data valid this cycle
//   fullBitNum   out  latched instruction for the ALU FSM
//   instr_valid  out  fullBitNum holds an executable instruction
//   PC_inc       in   increment the PC (EXEC only)
//   pc_load      in   load the PC with pc_load_val (EXEC only, beats PC_inc)
//   pc_load_val  in   jump target
//   done         in   current instruction finished (EXEC only)
//   pc           out  current program counter
//   halted       out  the halt word was fetched
//
// State table
//   state | meaning
//   IDLE  | one-cycle gap after reset before the first request
//   FETCH | mem_rd high at mem_addr=pc, waiting for mem_ack
//   EXEC  | instruction latched and valid, FSM may move the PC
//   HALT  | halt word seen; terminal until rst
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned            ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
  parameter logic [15:0]            HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic [15:0]       fullBitNum,
  output logic              instr_valid,
  input  logic              PC_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fullBitNum  <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (mem_ack) begin
            if (mem_data == HALT_WORD) begin
              // The halt word is never handed to the ALU FSM; fullBitNum keeps
              // the last executed instruction.
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              fullBitNum  <= mem_data;
              instr_valid <= 1'b1;
              state       <= EXEC;
            end
          end
        end

        EXEC: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end else if (PC_inc) begin
            pc <= pc + 1'b1;
          end
          // A PC update on the same edge as done is kept, so the following
          // fetch already uses the new address.
          if (done) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd   = (state == FETCH);
  assign mem_addr = pc;

endmodule
